gigerx_bcnt_gen: RTL and testbench
==================================

# gigerx_bcnt_gen

Per-frame byte-count generator for the GigE receive path. It sits directly upstream of the receive byte-count FIFO and monitors the 64-bit word stream being written into the receive data FIFO. For every completed frame it writes one 16-bit entry (status flags plus byte count) into the byte-count FIFO, holding the entry in a one-deep skid register while that FIFO is full.

## Interface
- MIN_LEN, 64, minimum legal frame length in bytes; shorter frames are flagged as runt.
- MAX_LEN, 1518, maximum legal frame length in bytes; longer frames are flagged as giant.
- BCNT_W, 14, byte-count field width; the count saturates at 2^BCNT_W-1.
- clk  in  1  single clock for all logic.
- reset_  in  1  asynchronous active-low reset.
- in_valid  in  1  data word valid this cycle.
- in_sop  in  1  first word of frame; qualified by in_valid.
- in_eop  in  1  last word of frame; qualified by in_valid. May coincide with in_sop.
- in_be  in  8  byte enables, contiguous from bit 0. Examined only on the eop word.
- in_err  in  1  MAC/CRC error for the frame; sampled on the eop word.
- bcnt_wrreq  out  1  write strobe to the byte-count FIFO.
- bcnt_data  out  16  entry: [15] err, [14] giant, [13:0] byte count.
- bcnt_full  in  1  byte-count FIFO full.
- drop_cnt  out  16  saturating count of entries lost because the skid register was occupied.
- orphan  out  1  one-cycle pulse for a valid word received in IDLE without in_sop; the word is ignored.

## Operation
- FSM states: IDLE and IN_FRAME.
  - IDLE, with in_valid&in_sop&~in_eop: go to IN_FRAME, acc = 8.
  - IDLE, with in_valid&in_sop&in_eop: single-word frame; close it immediately and stay in IDLE.
  - IN_FRAME, with in_valid&~in_eop&~in_sop: acc += 8.
  - IN_FRAME, with in_valid&in_eop: close the frame; go to IDLE.
  - IN_FRAME, with in_valid&in_sop (missing eop): close the current frame using acc only, with err=1. Start the new frame with acc = 8, or close it the same cycle if in_eop is also set.
- On the eop word, the byte count is acc + popcount(in_be). in_be=0 adds 0 bytes.
- Accumulator arithmetic is 16 bits. The value stored in the count field is min(count, 2^BCNT_W-1).
- Flags:
  - giant = count > MAX_LEN.
  - err = in_err | runt | giant | missing-eop, where runt = count < MIN_LEN.
- Skid register: a closed frame loads the entry into pend_data and sets pend=1.
- bcnt_wrreq = pend & ~bcnt_full. pend clears when the entry is written, unless a new entry loads in the same cycle.
- Simultaneous close and pend=1:
  - If bcnt_wrreq=1 that cycle, the new entry replaces the old one and pend stays 1. No loss.
  - If bcnt_wrreq=0, the new entry is discarded and drop_cnt increments, saturating at 0xFFFF. The old entry is kept.
- Reset: pend=0, state=IDLE, acc=0, drop_cnt=0, bcnt_wrreq=0, bcnt_data=0, orphan=0. A frame in progress at reset is lost, and words after reset are ignored until the next in_sop.

## Timing
- Latency: eop sampled at edge N puts pend=1 after edge N. bcnt_wrreq is high in cycle N+1 if bcnt_full=0.
- bcnt_data is registered and stable while pend=1.
- bcnt_wrreq depends combinationally on bcnt_full. No other output path is combinational from inputs.
- Sustains one entry per cycle (back-to-back single-word frames) while bcnt_full=0.
- in_valid=0 cycles inside a frame hold acc and state unchanged.
- orphan asserts the cycle after the offending word.

## Test plan
- 64-byte frame (8 words, in_be=0xFF on eop): bcnt_data=0x0040 with bcnt_wrreq for exactly one cycle, one cycle after the eop.
- 61-byte frame (eop in_be=0x1F): runt, bcnt_data=0x803D. Repeat a 64-byte frame with in_err=1 on eop: bcnt_data=0x8040.
- 200-word frame, eop in_be=0xFF (1600 bytes): bcnt_data=0xC640. 2100 full words plus eop in_be=0xFF (16808 bytes): bcnt_data=0xFFFF.
- Hold bcnt_full=1 and send two 64-byte frames: the first is held with pend=1 and bcnt_wrreq=0, the second is dropped, and drop_cnt=1. Release bcnt_full: exactly one write of 0x0040.
- Send sop plus 2 words (24 bytes), then sop of a 64-byte frame with no intervening eop: entries 0x8018 then 0x0040, in order. Back-to-back sop+eop single words with in_be=0x0F each cycle: one 0x8004 entry per cycle, drop_cnt=0.
- Assert reset_ low mid-frame with pend=1: all outputs go to 0 immediately. After release, mid-frame words pulse orphan and produce no entry. The next complete frame is counted correctly.

Source files
------------

// File: rtl/gigerx_bcnt_gen.sv
// rtl/gigerx_bcnt_gen.sv - per-frame byte-count entry generator for the GigE receive byte-count FIFO
module gigerx_bcnt_gen #(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518,
   parameter int BCNT_W  = 14
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        in_valid,
   input  logic        in_sop,
   input  logic        in_eop,
   input  logic [7:0]  in_be,
   input  logic        in_err,
   output logic        bcnt_wrreq,
   output logic [15:0] bcnt_data,
   input  logic        bcnt_full,
   output logic [15:0] drop_cnt,
   output logic        orphan
);

   typedef enum logic {IDLE, IN_FRAME} state_t;

   localparam logic [15:0] CNT_MAX = 16'((1 << BCNT_W) - 1);

   state_t      state, state_nxt;
   logic [15:0] acc, acc_nxt;
   logic        pend;
   logic [15:0] pend_data;
   logic [1:0]  n_close;
   logic [15:0] entry;
   logic        orphan_nxt;
   logic [15:0] be_cnt;
   logic        can_load;
   logic        load;
   logic [1:0]  n_drop;
   logic [16:0] drop_sum;

   function automatic logic [3:0] be_bytes(input logic [7:0] be);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + 4'(be[i]);
      return n;
   endfunction

   // Entry layout: [15] err, [14] giant, [13:0] saturated count.
   function automatic logic [15:0] make_entry(input logic [15:0] cnt, input logic err_in);
      logic       giant;
      logic       runt;
      logic [13:0] field;
      giant = cnt > 16'(MAX_LEN);
      runt  = cnt < 16'(MIN_LEN);
      field = (cnt > CNT_MAX) ? CNT_MAX[13:0] : cnt[13:0];
      return {err_in | runt | giant, giant, field};
   endfunction

   assign be_cnt = 16'(be_bytes(in_be));

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (in_valid) begin
         case (state)
            IDLE:     if (in_sop && !in_eop) state_nxt = IN_FRAME;
            IN_FRAME: if (in_eop) state_nxt = IDLE;
            default:  state_nxt = IDLE;
         endcase
      end
   end

   // A sop inside a frame closes the old frame (missing eop) and may also close a
   // single-word new frame in the same cycle; only the first entry can load.
   always_comb begin
      n_close    = 2'd0;
      entry      = 16'd0;
      acc_nxt    = acc;
      orphan_nxt = 1'b0;
      if (in_valid) begin
         case (state)
            IDLE: begin
               if (in_sop) begin
                  if (in_eop) begin
                     n_close = 2'd1;
                     entry   = make_entry(be_cnt, in_err);
                     acc_nxt = 16'd0;
                  end else begin
                     acc_nxt = 16'd8;
                  end
               end else begin
                  orphan_nxt = 1'b1;
               end
            end
            IN_FRAME: begin
               if (in_sop) begin
                  n_close = in_eop ? 2'd2 : 2'd1;
                  entry   = make_entry(acc, 1'b1);
                  acc_nxt = in_eop ? 16'd0 : 16'd8;
               end else if (in_eop) begin
                  n_close = 2'd1;
                  entry   = make_entry(acc + be_cnt, in_err);
                  acc_nxt = 16'd0;
               end else begin
                  acc_nxt = acc + 16'd8;
               end
            end
            default: acc_nxt = 16'd0;
         endcase
      end
   end

   assign bcnt_wrreq = pend & ~bcnt_full;
   assign bcnt_data  = pend_data;

   always_comb begin
      can_load = ~pend | bcnt_wrreq;
      load     = (n_close != 2'd0) & can_load;
      if (can_load) n_drop = (n_close == 2'd2) ? 2'd1 : 2'd0;
      else          n_drop = n_close;
      drop_sum = {1'b0, drop_cnt} + 17'(n_drop);
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         acc       <= 16'd0;
         pend      <= 1'b0;
         pend_data <= 16'd0;
         drop_cnt  <= 16'd0;
         orphan    <= 1'b0;
      end else begin
         acc    <= acc_nxt;
         orphan <= orphan_nxt;
         if (load) begin
            pend      <= 1'b1;
            pend_data <= entry;
         end else if (bcnt_wrreq) begin
            pend <= 1'b0;
         end
         drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
   end

endmodule

// File: tb/tb_gigerx_bcnt_gen.sv
// tb/tb_gigerx_bcnt_gen.sv - self-checking bench for gigerx_bcnt_gen
module tb_gigerx_bcnt_gen;

   logic        clk = 1'b0;
   logic        reset_ = 1'b0;
   logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, in_err = 1'b0;
   logic [7:0]  in_be = 8'h00;
   logic        bcnt_full = 1'b0;
   logic        bcnt_wrreq, orphan;
   logic [15:0] bcnt_data, drop_cnt;

   gigerx_bcnt_gen dut (
      .clk(clk), .reset_(reset_), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop),
      .in_be(in_be), .in_err(in_err), .bcnt_wrreq(bcnt_wrreq), .bcnt_data(bcnt_data),
      .bcnt_full(bcnt_full), .drop_cnt(drop_cnt), .orphan(orphan)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0, n_fail = 0, cyc = 0;
   logic [47:0] obs_q[$], exp_q[$];
   int          obs_orph[$], exp_orph[$];
   logic [15:0] mq[$];
   bit          m_in = 0;
   int          m_bytes = 0, m_drop = 0;
   bit          rnd_full = 0;

   function automatic logic [15:0] model_entry(input int count, input bit err);
      bit giant, runt;
      int f;
      giant = count > 1518;
      runt  = count < 64;
      f     = (count > 16383) ? 16383 : count;
      return {err | runt | giant, giant, f[13:0]};
   endfunction

   // One-deep skid as a bounded queue: an entry is kept only if the slot is free.
   function automatic void model_close(input int count, input bit err);
      if (mq.size() == 0) mq.push_back(model_entry(count, err));
      else if (m_drop < 65535) m_drop++;
   endfunction

   function automatic bit entries_differ();
      if (obs_q.size() != exp_q.size()) return 1;
      foreach (obs_q[i]) if (obs_q[i] !== exp_q[i]) return 1;
      return 0;
   endfunction

   function automatic bit orphans_differ();
      if (obs_orph.size() != exp_orph.size()) return 1;
      foreach (obs_orph[i]) if (obs_orph[i] != exp_orph[i]) return 1;
      return 0;
   endfunction

   function automatic logic [15:0] obs_data(input int i);
      return (i < obs_q.size()) ? obs_q[i][15:0] : 16'hxxxx;
   endfunction

   function automatic int obs_cyc(input int i);
      return (i < obs_q.size()) ? int'(obs_q[i][47:16]) : -1;
   endfunction

   task automatic clear_logs();
      obs_q.delete(); exp_q.delete(); obs_orph.delete(); exp_orph.delete();
   endtask

   task automatic step(input logic v, input logic sop, input logic eop,
                       input logic [7:0] be, input logic er);
      bit mwr;
      in_valid = v; in_sop = sop; in_eop = eop; in_be = be; in_err = er;
      if (rnd_full) bcnt_full = ($urandom_range(99) < 30);
      @(negedge clk);
      if (bcnt_wrreq === 1'b1) obs_q.push_back({32'(cyc), bcnt_data});
      if (orphan === 1'b1) obs_orph.push_back(cyc);
      mwr = (mq.size() > 0) && !bcnt_full;
      if (mwr) begin
         exp_q.push_back({32'(cyc), mq[0]});
         void'(mq.pop_front());
      end
      if (v && reset_) begin
         if (!m_in) begin
            if (sop) begin
               if (eop) model_close($countones(be), er);
               else begin m_in = 1; m_bytes = 8; end
            end else begin
               exp_orph.push_back(cyc + 1);
            end
         end else if (sop) begin
            model_close(m_bytes, 1);
            if (eop) begin model_close($countones(be), er); m_in = 0; end
            else m_bytes = 8;
         end else if (eop) begin
            model_close(m_bytes + $countones(be), er);
            m_in = 0;
         end else begin
            m_bytes += 8;
         end
      end
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 0, 8'h00, 0);
   endtask

   task automatic send_frame(input int nw, input logic [7:0] be, input logic er, input int gap);
      for (int i = 0; i < nw; i++) begin
         while (gap > 0 && $urandom_range(99) < gap) idle(1);
         if (i == nw - 1) step(1, i == 0, 1, be, er);
         else             step(1, i == 0, 0, 8'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bcnt_wrreq !== 1'b0) begin n_fail++; $display("FAIL reset_wrreq: got %b want 0", bcnt_wrreq); end
      n_cmp++; if (bcnt_data !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0000", bcnt_data); end
      n_cmp++; if (drop_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_drop: got %h want 0000", drop_cnt); end
      n_cmp++; if (orphan !== 1'b0) begin n_fail++; $display("FAIL reset_orphan: got %b want 0", orphan); end
      @(posedge clk); #1;
      reset_ = 1'b1;
   endtask

   task automatic test_basic();
      int eop_c;
      clear_logs();
      send_frame(8, 8'hFF, 0, 0);
      eop_c = cyc - 1;
      idle(4);
      n_cmp++;
      if (obs_q.size() != 1 || obs_data(0) !== 16'h0040 || obs_cyc(0) != eop_c + 1) begin
         n_fail++;
         $display("FAIL basic_64: got %0d writes, first %h at cycle %0d; want one 0040 at cycle %0d",
                  obs_q.size(), obs_data(0), obs_cyc(0), eop_c + 1);
      end
      n_cmp++; if (entries_differ()) begin n_fail++; $display("FAIL basic_model: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
   endtask

   task automatic test_runt_err();
      clear_logs();
      send_frame(8, 8'h1F, 0, 0);
      idle(2);
      send_frame(8, 8'hFF, 1, 0);
      idle(3);
      n_cmp++; if (obs_data(0) !== 16'h803D) begin n_fail++; $display("FAIL runt_61: got %h want 803d", obs_data(0)); end
      n_cmp++; if (obs_data(1) !== 16'h8040) begin n_fail++; $display("FAIL crc_err: got %h want 8040", obs_data(1)); end
      n_cmp++; if (entries_differ()) begin n_fail++; $display("FAIL runt_model: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
   endtask

   task automatic test_missing_eop();
      clear_logs();
      step(1, 1, 0, 8'h00, 0);
      step(1, 0, 0, 8'h00, 0);
      step(1, 0, 0, 8'h00, 0);
      send_frame(8, 8'hFF, 0, 0);
      idle(3);
      n_cmp++;
      if (obs_q.size() != 2 || obs_data(0) !== 16'h8018 || obs_data(1) !== 16'h0040) begin
         n_fail++;
         $display("FAIL missing_eop: got %0d writes %h %h want 8018 0040", obs_q.size(), obs_data(0), obs_data(1));
      end
      n_cmp++; if (entries_differ()) begin n_fail++; $display("FAIL missing_eop_model: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
   endtask

   task automatic test_back_to_back();
      int bad;
      clear_logs();
      bad = 0;
      repeat (20) step(1, 1, 1, 8'h0F, 0);
      idle(2);
      foreach (obs_q[i]) if (obs_data(i) !== 16'h8004 || (i > 0 && obs_cyc(i) != obs_cyc(i - 1) + 1)) bad++;
      n_cmp++; if (obs_q.size() != 20 || bad != 0) begin n_fail++; $display("FAIL b2b_rate: got %0d writes (%0d bad) want 20 of 8004", obs_q.size(), bad); end
      n_cmp++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b_drop: got %0d want 0", drop_cnt); end
      n_cmp++; if (entries_differ()) begin n_fail++; $display("FAIL b2b_model: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
   endtask

   task automatic test_giant();
      clear_logs();
      send_frame(200, 8'hFF, 0, 0);
      idle(2);
      send_frame(2101, 8'hFF, 0, 0);
      idle(2);
      n_cmp++; if (obs_data(0) !== 16'hC640) begin n_fail++; $display("FAIL giant_1600: got %h want c640", obs_data(0)); end
      n_cmp++; if (obs_data(1) !== 16'hFFFF) begin n_fail++; $display("FAIL giant_sat: got %h want ffff", obs_data(1)); end
      n_cmp++; if (entries_differ()) begin n_fail++; $display("FAIL giant_model: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
   endtask

   task automatic test_full();
      clear_logs();
      bcnt_full = 1'b1;
      send_frame(8, 8'hFF, 0, 0);
      send_frame(8, 8'hFF, 0, 0);
      idle(2);
      n_cmp++; if (bcnt_wrreq !== 1'b0 || obs_q.size() != 0) begin n_fail++; $display("FAIL full_hold: got wrreq %b with %0d writes want 0 and 0", bcnt_wrreq, obs_q.size()); end
      n_cmp++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL full_drop: got %0d want 1", drop_cnt); end
      bcnt_full = 1'b0;
      idle(4);
      n_cmp++; if (obs_q.size() != 1 || obs_data(0) !== 16'h0040) begin n_fail++; $display("FAIL full_release: got %0d writes first %h want one 0040", obs_q.size(), obs_data(0)); end
      n_cmp++; if (entries_differ()) begin n_fail++; $display("FAIL full_model: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
   endtask

   task automatic test_reset_mid();
      bcnt_full = 1'b1;
      send_frame(8, 8'hFF, 0, 0);
      step(1, 1, 0, 8'h00, 0);
      step(1, 0, 0, 8'h00, 0);
      #2;
      bcnt_full = 1'b0;
      reset_ = 1'b0;
      #1;
      n_cmp++;
      if (bcnt_wrreq !== 1'b0 || bcnt_data !== 16'h0 || drop_cnt !== 16'h0 || orphan !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_async: got wrreq %b data %h drop %h orphan %b want all 0", bcnt_wrreq, bcnt_data, drop_cnt, orphan);
      end
      mq.delete(); m_in = 0; m_drop = 0;
      clear_logs();
      idle(2);
      reset_ = 1'b1;
      step(1, 0, 0, 8'h00, 0);
      step(1, 0, 0, 8'h00, 0);
      step(1, 0, 1, 8'hFF, 0);
      send_frame(8, 8'hFF, 0, 0);
      idle(3);
      n_cmp++; if (obs_orph.size() != 3 || orphans_differ()) begin n_fail++; $display("FAIL reset_orphan_pulses: got %0d want 3", obs_orph.size()); end
      n_cmp++; if (obs_q.size() != 1 || obs_data(0) !== 16'h0040) begin n_fail++; $display("FAIL reset_next_frame: got %0d writes first %h want one 0040", obs_q.size(), obs_data(0)); end
   endtask

   task automatic test_random();
      int k;
      clear_logs();
      rnd_full = 1;
      for (int f = 0; f < 200; f++) begin
         k = $urandom_range(99);
         if (k < 8) begin
            step(1, 0, 1'($urandom), 8'h00, 0);
         end else if (k < 20) begin
            send_frame($urandom_range(1, 6), 8'h00, 0, 20);
            in_sop = 0;
            step(1, 0, 0, 8'h00, 0);
         end else begin
            send_frame($urandom_range(1, 120), 8'((9'h1 << $urandom_range(8)) - 1), 1'($urandom_range(99) < 15), 20);
         end
      end
      rnd_full = 0;
      bcnt_full = 1'b0;
      idle(4);
      n_cmp++; if (entries_differ()) begin n_fail++; $display("FAIL random_entries: got %0d writes want %0d", obs_q.size(), exp_q.size()); end
      n_cmp++; if (orphans_differ()) begin n_fail++; $display("FAIL random_orphans: got %0d want %0d", obs_orph.size(), exp_orph.size()); end
      n_cmp++; if (drop_cnt !== 16'(m_drop)) begin n_fail++; $display("FAIL random_drop: got %0d want %0d", drop_cnt, m_drop); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_runt_err();
      test_missing_eop();
      test_back_to_back();
      test_giant();
      test_full();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
